// File: rtl/trace_seq_pkg.sv
// rtl/trace_seq_pkg.sv - shared types and constants for the trace window sequencer
package trace_seq_pkg;

  typedef enum logic [1:0] {CH_ON, CH_OFF, CH_LIMITED} chan_state_e;

  typedef enum logic [1:0] {G_IDLE, G_RUN, G_DONE} glob_state_e;

  // Listed in descending priority; the budget-exhaust off sits with the scheduled off.
  typedef enum logic [2:0] {
    EV_NONE,
    EV_FINISH,
    EV_LIMIT,
    EV_OFF,
    EV_ALL,
    EV_ON
  } event_e;

  localparam logic [31:0] CYC_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/trace_window_seq_if.sv
// rtl/trace_window_seq_if.sv - schedule inputs and dump-control outputs of the sequencer
interface trace_window_seq_if #(
  parameter int CYC_W   = 32,
  parameter int NUM_CH  = 2,
  parameter int BYTES_W = 24
);
  logic                        start;
  logic [NUM_CH*CYC_W-1:0]     off_cyc;
  logic [NUM_CH*CYC_W-1:0]     all_cyc;
  logic [NUM_CH*CYC_W-1:0]     on_cyc;
  logic [CYC_W-1:0]            finish_cyc;
  logic [NUM_CH*BYTES_W-1:0]   byte_limit;

  logic [CYC_W-1:0]            cyc;
  logic [NUM_CH-1:0]           trace_on;
  logic [NUM_CH-1:0]           dump_off_p;
  logic [NUM_CH-1:0]           dump_on_p;
  logic [NUM_CH-1:0]           dump_all_p;
  logic [NUM_CH-1:0]           dump_flush_p;
  logic [NUM_CH-1:0]           limit_hit;
  logic                        finish_p;
  logic                        done;

  modport master (
    output start, off_cyc, all_cyc, on_cyc, finish_cyc, byte_limit,
    input  cyc, trace_on, dump_off_p, dump_on_p, dump_all_p, dump_flush_p,
           limit_hit, finish_p, done
  );

  modport slave (
    input  start, off_cyc, all_cyc, on_cyc, finish_cyc, byte_limit,
    output cyc, trace_on, dump_off_p, dump_on_p, dump_all_p, dump_flush_p,
           limit_hit, finish_p, done
  );
endinterface

// File: rtl/trace_chan_fsm.sv
// rtl/trace_chan_fsm.sv - one trace channel: on/off/limited state, byte budget, event pulses
module trace_chan_fsm
  import trace_seq_pkg::*;
#(
  parameter int CYC_W     = 32,
  parameter int BYTES_W   = 24,
  parameter int REC_BYTES = 16
) (
  input  logic               clk,
  input  logic               reset_l,
  input  logic               start_ev,
  input  logic               run,
  input  logic               finish_ev,
  input  logic [CYC_W-1:0]   cyc,
  input  logic [CYC_W-1:0]   off_cyc,
  input  logic [CYC_W-1:0]   all_cyc,
  input  logic [CYC_W-1:0]   on_cyc,
  input  logic [BYTES_W-1:0] byte_limit,
  output logic               trace_on,
  output logic               dump_off_p,
  output logic               dump_on_p,
  output logic               dump_all_p,
  output logic               dump_flush_p,
  output logic               limit_hit
);

  localparam int AW = BYTES_W + 1;
  localparam logic [AW-1:0] REC = AW'(REC_BYTES);

  chan_state_e        st_q, st_d;
  logic [BYTES_W-1:0] acc_q, acc_d;
  logic               trace_d, off_d, on_d, all_d, hit_d;
  logic [AW-1:0]      acc_next;
  logic [BYTES_W-1:0] acc_sat;
  logic               over;
  event_e             ev;

  assign acc_next = {1'b0, acc_q} + REC;
  assign acc_sat  = acc_next[BYTES_W] ? {BYTES_W{1'b1}} : acc_next[BYTES_W-1:0];
  assign over     = (byte_limit != '0) && (acc_next > {1'b0, byte_limit});

  always_comb begin
    ev = EV_NONE;
    if (finish_ev) begin
      ev = EV_FINISH;
    end else if (run) begin
      if (st_q == CH_ON && over)
        ev = EV_LIMIT;
      else if (st_q == CH_ON && cyc == off_cyc)
        ev = EV_OFF;
      else if (cyc == all_cyc)
        ev = EV_ALL;
      else if (st_q == CH_OFF && cyc == on_cyc)
        ev = EV_ON;
    end
  end

  always_comb begin
    st_d    = st_q;
    acc_d   = acc_q;
    trace_d = trace_on;
    hit_d   = limit_hit;
    off_d   = 1'b0;
    on_d    = 1'b0;
    all_d   = 1'b0;
    if (start_ev) begin
      st_d    = CH_ON;
      acc_d   = '0;
      trace_d = 1'b1;
      hit_d   = 1'b0;
    end else begin
      // A cycle spent tracing is charged unless it is the one that blows the budget.
      if (run && st_q == CH_ON && ev != EV_LIMIT)
        acc_d = acc_sat;
      case (ev)
        EV_FINISH: trace_d = 1'b0;
        EV_LIMIT: begin
          st_d    = CH_LIMITED;
          trace_d = 1'b0;
          hit_d   = 1'b1;
          off_d   = 1'b1;
        end
        EV_OFF: begin
          st_d    = CH_OFF;
          trace_d = 1'b0;
          off_d   = 1'b1;
        end
        EV_ALL: all_d = 1'b1;
        EV_ON: begin
          st_d    = CH_ON;
          trace_d = 1'b1;
          on_d    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      st_q         <= CH_ON;
      acc_q        <= '0;
      trace_on     <= 1'b0;
      dump_off_p   <= 1'b0;
      dump_on_p    <= 1'b0;
      dump_all_p   <= 1'b0;
      dump_flush_p <= 1'b0;
      limit_hit    <= 1'b0;
    end else begin
      st_q         <= st_d;
      acc_q        <= acc_d;
      trace_on     <= trace_d;
      dump_off_p   <= off_d;
      dump_on_p    <= on_d;
      dump_all_p   <= all_d;
      dump_flush_p <= all_d;
      limit_hit    <= hit_d;
    end
  end

endmodule

// File: rtl/trace_window_seq.sv
// rtl/trace_window_seq.sv - cycle counter, global run FSM and per-channel trace window sequencers
module trace_window_seq
  import trace_seq_pkg::*;
#(
  parameter int CYC_W     = 32,
  parameter int NUM_CH    = 2,
  parameter int BYTES_W   = 24,
  parameter int REC_BYTES = 16
) (
  input logic               clk,
  input logic               reset_l,
  trace_window_seq_if.slave bus
);

  localparam logic [CYC_W-1:0] CYC_SAT = CYC_MAX[CYC_W-1:0];
  localparam logic [CYC_W-1:0] CYC_ONE = {{(CYC_W-1){1'b0}}, 1'b1};

  glob_state_e      g_q, g_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             finish_q, finish_d;
  logic             done_q, done_d;
  logic             start_ev, finish_ev, run;

  logic [NUM_CH-1:0] trace_on_w, off_w, on_w, all_w, flush_w, hit_w;

  always_comb begin
    g_d       = g_q;
    cyc_d     = cyc_q;
    finish_d  = 1'b0;
    done_d    = done_q;
    start_ev  = 1'b0;
    finish_ev = 1'b0;
    case (g_q)
      G_IDLE: begin
        if (bus.start) begin
          g_d      = G_RUN;
          cyc_d    = CYC_ONE;
          start_ev = 1'b1;
        end
      end
      G_RUN: begin
        // cyc freezes at the finishing value so the bench can read where it stopped.
        if (cyc_q == bus.finish_cyc) begin
          g_d       = G_DONE;
          finish_d  = 1'b1;
          done_d    = 1'b1;
          finish_ev = 1'b1;
        end else if (cyc_q != CYC_SAT) begin
          cyc_d = cyc_q + CYC_ONE;
        end
      end
      default: ;
    endcase
  end

  assign run = (g_q == G_RUN) && !finish_ev;

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      g_q      <= G_IDLE;
      cyc_q    <= '0;
      finish_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      g_q      <= g_d;
      cyc_q    <= cyc_d;
      finish_q <= finish_d;
      done_q   <= done_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    trace_chan_fsm #(
      .CYC_W    (CYC_W),
      .BYTES_W  (BYTES_W),
      .REC_BYTES(REC_BYTES)
    ) u_ch (
      .clk         (clk),
      .reset_l     (reset_l),
      .start_ev    (start_ev),
      .run         (run),
      .finish_ev   (finish_ev),
      .cyc         (cyc_q),
      .off_cyc     (bus.off_cyc[i*CYC_W +: CYC_W]),
      .all_cyc     (bus.all_cyc[i*CYC_W +: CYC_W]),
      .on_cyc      (bus.on_cyc[i*CYC_W +: CYC_W]),
      .byte_limit  (bus.byte_limit[i*BYTES_W +: BYTES_W]),
      .trace_on    (trace_on_w[i]),
      .dump_off_p  (off_w[i]),
      .dump_on_p   (on_w[i]),
      .dump_all_p  (all_w[i]),
      .dump_flush_p(flush_w[i]),
      .limit_hit   (hit_w[i])
    );
  end

  assign bus.cyc          = cyc_q;
  assign bus.trace_on     = trace_on_w;
  assign bus.dump_off_p   = off_w;
  assign bus.dump_on_p    = on_w;
  assign bus.dump_all_p   = all_w;
  assign bus.dump_flush_p = flush_w;
  assign bus.limit_hit    = hit_w;
  assign bus.finish_p     = finish_q;
  assign bus.done         = done_q;

endmodule

// File: doc/trace_window_seq.md
Name: trace_window_seq

Overview:
- Cycle-driven dump-control sequencer for trace regression benches.
- Generalises the fixed "off at 3, all/flush at 5, on at 7, finish at 10" schedule to NUM_CH independently programmable channels, each with its own off/all/on window.
- Adds a per-channel byte budget, equivalent to a dump limit, that forces tracing off when it is exhausted.
- Sits beside the DUT top. Its pulse outputs are consumed by bench-side $dumpoff/$dumpon/$dumpall/$dumpflush/$finish shims.

Parameters:
- CYC_W, 32: width of the cycle counter and all cycle-compare fields.
- NUM_CH, 2: number of independent trace channels.
- BYTES_W, 24: width of the per-channel byte accumulator and the limit.
- REC_BYTES, 16: bytes charged per cycle while a channel is tracing.

Ports:
- clk  in  1  sole clock.
- reset_l  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; begins sequencing from cycle 1.
- off_cyc  in  NUM_CH*CYC_W  per-channel cycle at which tracing turns off.
- all_cyc  in  NUM_CH*CYC_W  per-channel cycle for the dumpall+flush pulse.
- on_cyc  in  NUM_CH*CYC_W  per-channel cycle at which tracing turns back on.
- finish_cyc  in  CYC_W  global end cycle.
- byte_limit  in  NUM_CH*BYTES_W  per-channel budget; 0 means unlimited.
- cyc  out  CYC_W  current cycle count.
- trace_on  out  NUM_CH  level: channel is currently tracing.
- dump_off_p, dump_on_p, dump_all_p, dump_flush_p  out  NUM_CH each  single-cycle event pulses.
- limit_hit  out  NUM_CH  sticky: budget exhausted.
- finish_p  out  1  single-cycle pulse at finish.
- done  out  1  sticky after finish.

Behaviour:
- Reset (reset_l low, asynchronous): every output goes to 0, including cyc=0, trace_on=0, all pulses 0, limit_hit=0 and done=0. Byte accumulators clear. Global FSM goes to IDLE.
- Global FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on start. On the next edge cyc=1 and every trace_on=1.
  - RUN: cyc increments by 1 per clock and saturates at all-ones (no wrap). Compares use the registered cyc value.
  - RUN -> DONE when cyc==finish_cyc. On that edge finish_p pulses for one cycle, done=1 and all trace_on clear.
  - DONE is terminal until reset. start is ignored in RUN and DONE.
- Per-channel FSM states: ON, OFF, LIMITED. Evaluated only in RUN.
  - Event priority within a cycle: finish > off > all > on. At most one per-channel pulse fires per cycle.
  - ON and cyc==off_cyc[i]: go to OFF; dump_off_p[i]=1 and trace_on[i]=0 on the next edge.
  - Any state and cyc==all_cyc[i] with no higher-priority event: dump_all_p[i]=1 and dump_flush_p[i]=1 together for one cycle. State is unchanged.
  - OFF and cyc==on_cyc[i]: go to ON; dump_on_p[i]=1 and trace_on[i]=1.
  - ON and cyc==on_cyc[i]: no pulse (idempotent).
  - OFF and cyc==off_cyc[i]: no pulse (idempotent).
  - Pulse and level outputs are registered: an event at cycle N is visible during the cycle after cyc becomes N.
- Budget:
  - While trace_on[i]=1, acc[i] += REC_BYTES each cycle. The accumulator saturates.
  - If byte_limit[i]!=0 and acc[i]+REC_BYTES > byte_limit[i], go to LIMITED instead of adding. This sets trace_on[i]=0, limit_hit[i]=1 and a one-cycle dump_off_p[i].
  - LIMITED ignores later on_cyc events. dumpall still pulses.
  - byte_limit is sampled each cycle. Changing it mid-run is allowed but does not un-latch LIMITED.
- Reset asserted mid-RUN: immediate return to the reset values. No finish_p is emitted.
- A compare value of 0 never matches, because cyc starts at 1. This disables the corresponding event.

Decomposition:
- Shared package trace_seq_pkg holds:
  - typedef chan_state_e {CH_ON, CH_OFF, CH_LIMITED};
  - typedef glob_state_e {G_IDLE, G_RUN, G_DONE};
  - the event-priority enum;
  - localparam CYC_MAX.
- One natural sub-module, trace_chan_fsm. It holds a single channel's state, accumulator and pulse registers, and is instantiated NUM_CH times in a generate loop. The parent owns cyc, the global FSM and finish.

Test Plan:
- Default schedule, ch0: off=3, all=5, on=7, finish=10, no limit. Expected: trace_on0 drops after cyc 3, dump_all_p0 and dump_flush_p0 pulse at cyc 5, trace_on0 rises at cyc 7, finish_p at cyc 10, done=1.
- Two channels with independent windows: ch0 off=3/on=7, ch1 off=4/on=6. Expected: pulses land on the correct bits at 3, 4, 6 and 7, with no cross-talk.
- Collision: off=all=on=5 on ch0. Expected: only dump_off_p0 fires at 5 and trace_on0 ends 0. With finish_cyc also 5, only finish_p fires and done=1.
- Budget: REC_BYTES=16, byte_limit=64, no off/on events. Expected: four charged cycles, then limit_hit0=1 and a dump_off_p0 pulse. A later on_cyc produces no dump_on_p0.
- Async reset asserted at cyc 6 between clock edges. Expected: every output is 0 immediately. A new start restarts at cyc=1 with a clean accumulator.
- Zero fields: all compare fields and finish_cyc = 0. Expected: no pulses ever, trace_on stays 1, and cyc keeps counting, saturating at 2^CYC_W-1 in a reduced-width CYC_W=4 run.
